// File: rtl/pmesh_store_splitter.sv
// +----------------------------------------------------------------------------+
// | Module      : pmesh_store_splitter                                         |
// | Description : Splits one 64-bit AXI write beat into naturally aligned      |
// |               1/2/4/8-byte P-Mesh stores and tracks their acknowledgements.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module pmesh_store_splitter #(
    parameter int ADDR_WIDTH      = 40,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [7:0]            s_wstrb,
    input  logic [63:0]           s_wdata,
    output logic                  pm_valid,
    input  logic                  pm_ready,
    output logic [ADDR_WIDTH-1:0] pm_addr,
    output logic [2:0]            pm_size,
    output logic [63:0]           pm_data,
    output logic                  pm_last,
    input  logic                  pm_ack,
    output logic                  beat_done,
    output logic                  err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [3:0] c_MAX_OUT = 4'(MAX_OUTSTANDING);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  r_live;
    logic [7:0]            r_mask;
    logic [ADDR_WIDTH-4:0] r_base;
    logic [3:0]            r_outst;

    logic [3:0]            w_out_nxt;
    logic                  w_spurious;
    logic                  w_hs;
    logic                  w_accept;
    logic                  w_load;

    logic [2:0]            w_pos;
    logic [7:0]            w_win;
    logic [7:0]            w_ones;
    logic [7:0]            w_chunk;
    logic [2:0]            w_size;
    logic                  w_last;
    logic                  w_unused_addr;

    // Address bits [2:0] are replaced by the chunk offset
    assign w_unused_addr = ^s_addr[2:0];

    assign w_hs     = pm_valid & pm_ready;
    assign w_accept = s_valid & s_ready;

    // Largest naturally aligned run starting at the lowest pending byte
    always_comb begin
        w_pos = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_pos = 3'(i);
            end
        end
        w_win = r_mask >> w_pos;
        if ((w_pos == 3'd0) && (r_mask == 8'hFF)) begin
            w_size = 3'd4;
            w_ones = 8'hFF;
        end else if ((w_pos[1:0] == 2'b00) && ((w_win & 8'h0F) == 8'h0F)) begin
            w_size = 3'd3;
            w_ones = 8'h0F;
        end else if ((w_pos[0] == 1'b0) && ((w_win & 8'h03) == 8'h03)) begin
            w_size = 3'd2;
            w_ones = 8'h03;
        end else begin
            w_size = 3'd1;
            w_ones = 8'h01;
        end
        w_chunk = w_ones << w_pos;
        w_last  = ((r_mask & ~w_chunk) == 8'h00);
    end

    // Credit count as it will stand after this edge
    always_comb begin
        w_out_nxt  = r_outst;
        w_spurious = 1'b0;
        if (w_hs && !pm_ack) begin
            w_out_nxt = r_outst + 4'd1;
        end else if (!w_hs && pm_ack) begin
            if (r_outst != 4'd0) begin
                w_out_nxt = r_outst - 4'd1;
            end else begin
                w_spurious = 1'b1;
            end
        end
    end

    assign w_load = (r_state == c_ISSUE) && (r_mask != 8'h00) &&
                    (!pm_valid || pm_ready) && (w_out_nxt < c_MAX_OUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = (s_wstrb != 8'h00) ? c_ISSUE : c_DONE;
                end
            end
            c_ISSUE: begin
                if (w_hs && pm_last) begin
                    w_next_state = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (w_out_nxt == 4'd0) begin
                    w_next_state = c_DONE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_comb begin
        s_ready   = (r_state == c_IDLE) && r_live;
        beat_done = (r_state == c_DONE);
    end

    // Payload registers: loaded once per chunk, held while the encoder stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask   <= 8'h00;
            r_base   <= '0;
            pm_valid <= 1'b0;
            pm_addr  <= '0;
            pm_size  <= 3'd0;
            pm_last  <= 1'b0;
            pm_data  <= 64'd0;
        end else begin
            if (w_accept) begin
                r_mask  <= s_wstrb;
                r_base  <= s_addr[ADDR_WIDTH-1:3];
                pm_data <= s_wdata;
            end
            if (w_load) begin
                pm_valid <= 1'b1;
                pm_addr  <= {r_base, w_pos};
                pm_size  <= w_size;
                pm_last  <= w_last;
                r_mask   <= r_mask & ~w_chunk;
            end else if (w_hs) begin
                pm_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outst <= 4'd0;
            err     <= 1'b0;
        end else begin
            r_outst <= w_out_nxt;
            if (w_spurious) begin
                err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
